vec_exec_unit: RTL and testbench

VEC_EXEC_UNIT -- requirements
Module: vec_exec_unit

---
 rtl/vec_exec_unit.sv | 200 ++++++++++++++++++++
 tb/tb_vec_exec_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_exec_unit.sv
// vec_exec_unit: vector load/store/add/sub over NVREG registers of LANES x LANE_W; optional VEC_SAT_EN gives saturating lane arithmetic.
// Latency: start cycle is 0; VLOAD done in cycle LANES+2, VSTORE in LANES+1, VADD/VSUB in cycle 2.
// Backpressure: none; start is sampled only in IDLE and ignored while busy; memory has fixed one-cycle read latency.
module vec_exec_unit #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int ADDR_W = 8,
   parameter int NVREG  = 4,
   localparam int VIDX_W = $clog2(NVREG)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [1:0]                op,
   input  logic [VIDX_W-1:0]         vd,
   input  logic [VIDX_W-1:0]         vs1,
   input  logic [VIDX_W-1:0]         vs2,
   input  logic [ADDR_W-1:0]         base_addr,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [LANE_W-1:0]         mem_wdata,
   output logic                      mem_wren,
   output logic                      mem_rden,
   input  logic [LANE_W-1:0]         mem_rdata,
   output logic [LANES-1:0]          carry,
   input  logic [VIDX_W-1:0]         dbg_sel,
   output logic [LANES*LANE_W-1:0]   dbg_vreg
);

   localparam int VEC_W = LANES * LANE_W;
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   localparam logic [1:0] OP_VLOAD  = 2'b00;
   localparam logic [1:0] OP_VSTORE = 2'b01;
   localparam logic [1:0] OP_VADD   = 2'b10;
   localparam logic [1:0] OP_VSUB   = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [VIDX_W-1:0]    vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [LANE_W-1:0]    mem_wdata_q, mem_wdata_d;
   logic                 mem_rden_q, mem_rden_d, mem_wren_q, mem_wren_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [LANES-1:0]     carry_q, carry_d;
   logic [VEC_W-1:0]     stage_q, stage_d;
   logic                 cap_vld_q, cap_vld_d;
   logic [CNT_W-1:0]     cap_idx_q, cap_idx_d;
   logic [VEC_W-1:0]     vreg_q [NVREG];
   logic [VEC_W-1:0]     vreg_d [NVREG];

   logic [VEC_W-1:0]     src_a, src_b, alu_res;
   logic [LANES-1:0]     alu_cy;
   logic [LANE_W:0]      lane_s;

   assign src_a     = vreg_q[vs1_q];
   assign src_b     = vreg_q[vs2_q];
   assign dbg_vreg  = vreg_q[dbg_sel];
   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rden  = mem_rden_q;
   assign mem_wren  = mem_wren_q;
   assign carry     = carry_q;

   // Lane-wise add/subtract; the extra top bit of each lane result is its carry (add) or borrow (sub).
   always_comb begin
      alu_res = '0;
      alu_cy  = '0;
      lane_s  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (op_q == OP_VSUB)
            lane_s = {1'b0, src_a[i*LANE_W +: LANE_W]} - {1'b0, src_b[i*LANE_W +: LANE_W]};
         else
            lane_s = {1'b0, src_a[i*LANE_W +: LANE_W]} + {1'b0, src_b[i*LANE_W +: LANE_W]};
         alu_cy[i] = lane_s[LANE_W];
`ifdef VEC_SAT_EN
         if (lane_s[LANE_W])
            alu_res[i*LANE_W +: LANE_W] = (op_q == OP_VSUB) ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
         else
            alu_res[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
`else
         alu_res[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
`endif
      end
   end

   // Next-state logic: sequencing, registered memory strobes, read-data staging and register writeback.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      vd_d        = vd_q;
      vs1_d       = vs1_q;
      vs2_d       = vs2_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rden_d  = 1'b0;
      mem_wren_d  = 1'b0;
      carry_d     = carry_q;
      vreg_d      = vreg_q;
      stage_d     = stage_q;
      // A read strobed last cycle returns its data this cycle.
      cap_vld_d   = mem_rden_q;
      cap_idx_d   = cnt_q;
      if (cap_vld_q)
         stage_d[cap_idx_q*LANE_W +: LANE_W] = mem_rdata;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               op_d        = op;
               vd_d        = vd;
               vs1_d       = vs1;
               vs2_d       = vs2;
               cnt_d       = '0;
               mem_addr_d  = base_addr;
               mem_wdata_d = vreg_q[vs1][LANE_W-1:0];
               mem_rden_d  = (op == OP_VLOAD);
               mem_wren_d  = (op == OP_VSTORE);
            end
         end
         RUN: begin
            if (op_q == OP_VADD || op_q == OP_VSUB) begin
               vreg_d[vd_q] = alu_res;
               carry_d      = alu_cy;
               state_d      = DONE;
            end else if (cnt_q == LAST_LANE) begin
               state_d = (op_q == OP_VLOAD) ? DRAIN : DONE;
            end else begin
               cnt_d       = cnt_q + CNT_W'(1);
               mem_addr_d  = mem_addr_q + ADDR_W'(1);
               mem_rden_d  = (op_q == OP_VLOAD);
               mem_wren_d  = (op_q == OP_VSTORE);
               mem_wdata_d = vreg_q[vs1_q][cnt_d*LANE_W +: LANE_W];
            end
         end
         DRAIN: begin
            // stage_d already holds the final lane captured this cycle.
            vreg_d[vd_q] = stage_d;
            state_d      = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State register with synchronous reset that abandons any in-flight operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         vd_q        <= '0;
         vs1_q       <= '0;
         vs2_q       <= '0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rden_q  <= 1'b0;
         mem_wren_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         carry_q     <= '0;
         stage_q     <= '0;
         cap_vld_q   <= 1'b0;
         cap_idx_q   <= '0;
         for (int i = 0; i < NVREG; i++)
            vreg_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         vd_q        <= vd_d;
         vs1_q       <= vs1_d;
         vs2_q       <= vs2_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rden_q  <= mem_rden_d;
         mem_wren_q  <= mem_wren_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         carry_q     <= carry_d;
         stage_q     <= stage_d;
         cap_vld_q   <= cap_vld_d;
         cap_idx_q   <= cap_idx_d;
         vreg_q      <= vreg_d;
      end
   end

endmodule

// File: tb/tb_vec_exec_unit.sv
// tb_vec_exec_unit: directed vectors for vec_exec_unit with a queue-based scoreboard.
// Stimulus pushes expected memory strobes and done pulses; a negedge monitor pops and compares.
// Expected values follow the wrap build, or the saturating build when VEC_SAT_EN is defined.
module tb_vec_exec_unit;

   localparam logic [1:0] OP_VLOAD  = 2'b00;
   localparam logic [1:0] OP_VSTORE = 2'b01;
   localparam logic [1:0] OP_VADD   = 2'b10;
   localparam logic [1:0] OP_VSUB   = 2'b11;

`ifdef VEC_SAT_EN
   localparam logic [31:0] ADD_RES = 32'hFF02FF02;
   localparam logic [31:0] SUB_RES = 32'h00040004;
`else
   localparam logic [31:0] ADD_RES = 32'h00020002;
   localparam logic [31:0] SUB_RES = 32'hFF04FF04;
`endif

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_DONE = 2;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [1:0]  op, vd, vs1, vs2, dbg_sel;
   logic [7:0]  base_addr;
   logic        busy, done, mem_wren, mem_rden;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  carry;
   logic [31:0] dbg_vreg;

   logic [7:0]  mem [256];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_addr = 8'h0, pl_dat = 8'h0;

   typedef struct {
      int          kind;
      int          cyc;
      logic [7:0]  addr;
      logic [31:0] val;
      logic [3:0]  cy;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   mon_kind;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   vec_exec_unit #(.LANES(4), .LANE_W(8), .ADDR_W(8), .NVREG(4)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .vd(vd), .vs1(vs1), .vs2(vs2), .base_addr(base_addr),
      .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_rdata(mem_rdata), .carry(carry), .dbg_sel(dbg_sel), .dbg_vreg(dbg_vreg)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Single-port memory model, one-cycle read latency, with a preload port for the bench.
   always @(posedge clock) begin
      if (pl_we)
         mem[pl_addr] <= pl_dat;
      else if (mem_wren)
         mem[mem_addr] <= mem_wdata;
      if (mem_rden)
         mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [7:0] a,
                       input logic [31:0] v, input logic [3:0] cy);
      exp_t e;
      e.kind = kind; e.cyc = c; e.addr = a; e.val = v; e.cy = cy;
      expq.push_back(e);
   endtask

   // Monitor: every strobe or done pulse must match the head of the expectation queue.
   always @(negedge clock) begin
      if (mem_rden && mem_wren)
         chk("strobe_overlap", {31'b0, mem_rden & mem_wren}, 32'd0);
      if (mem_rden || mem_wren || done) begin
         if (expq.size() == 0) begin
            chk("unexpected_event", {29'b0, mem_rden, mem_wren, done}, 32'd0);
         end else begin
            mon_e    = expq.pop_front();
            mon_kind = mem_rden ? K_RD : (mem_wren ? K_WR : K_DONE);
            chk("event_kind", mon_kind, mon_e.kind);
            chk("event_cycle", cyc, mon_e.cyc);
            if (mon_e.kind != K_DONE)
               chk("mem_addr", {24'b0, mem_addr}, {24'b0, mon_e.addr});
            if (mon_e.kind == K_WR)
               chk("mem_wdata", {24'b0, mem_wdata}, mon_e.val);
            if (mon_e.kind == K_DONE) begin
               chk("done_vreg", dbg_vreg, mon_e.val);
               chk("done_carry", {28'b0, carry}, {28'b0, mon_e.cy});
            end
         end
      end
   end

   task automatic put_vec(input logic [7:0] b, input logic [31:0] v);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         pl_we = 1'b1; pl_addr = b + 8'(k); pl_dat = v[k*8 +: 8];
         @(negedge clock);
         pl_we = 1'b0;
      end
   endtask

   // Issue one op, queue its expected strobes and done pulse, and wait (bounded) for idle.
   task automatic run_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [7:0] b, input logic [1:0] sel,
                         input logic [31:0] ev, input logic [3:0] ecy);
      int t0;
      int n;
      @(negedge clock);
      t0 = cyc;
      op = o; vd = d; vs1 = s1; vs2 = s2; base_addr = b; dbg_sel = sel; start = 1'b1;
      case (o)
         OP_VLOAD: begin
            for (int k = 1; k <= 4; k++) push(K_RD, t0 + k, b + 8'(k - 1), 32'd0, 4'd0);
            push(K_DONE, t0 + 6, 8'd0, ev, ecy);
         end
         OP_VSTORE: begin
            for (int k = 1; k <= 4; k++)
               push(K_WR, t0 + k, b + 8'(k - 1), {24'b0, ev[(k-1)*8 +: 8]}, 4'd0);
            push(K_DONE, t0 + 5, 8'd0, ev, ecy);
         end
         default: push(K_DONE, t0 + 2, 8'd0, ev, ecy);
      endcase
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("op_completes", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int n;
      // Reset held with start high: reset must win.
      reset = 1'b1; start = 1'b1; op = OP_VLOAD; vd = 2'd0; vs1 = 2'd0; vs2 = 2'd0;
      base_addr = 8'd0; dbg_sel = 2'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0; start = 1'b0;
      @(negedge clock);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_strobes", {30'b0, mem_rden, mem_wren}, 32'd0);
      chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
      chk("rst_carry", {28'b0, carry}, 32'd0);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1 chk("rst_vreg", dbg_vreg, 32'd0);
      end

      put_vec(8'd10, 32'h04030201);
      put_vec(8'd20, 32'hA1B2C3D4);
      put_vec(8'd30, 32'hFF01FF01);
      put_vec(8'd40, 32'h01010101);
      put_vec(8'd50, 32'h00050005);

      run_op(OP_VLOAD,  2'd1, 2'd0, 2'd0, 8'd10,  2'd1, 32'h04030201, 4'b0000);
      run_op(OP_VLOAD,  2'd2, 2'd0, 2'd0, 8'd20,  2'd2, 32'hA1B2C3D4, 4'b0000);
      run_op(OP_VSTORE, 2'd0, 2'd2, 2'd0, 8'hFE,  2'd2, 32'hA1B2C3D4, 4'b0000);
      run_op(OP_VLOAD,  2'd0, 2'd0, 2'd0, 8'd30,  2'd0, 32'hFF01FF01, 4'b0000);
      run_op(OP_VLOAD,  2'd1, 2'd0, 2'd0, 8'd40,  2'd1, 32'h01010101, 4'b0000);
      run_op(OP_VADD,   2'd3, 2'd0, 2'd1, 8'd0,   2'd3, ADD_RES,      4'b1010);
      run_op(OP_VLOAD,  2'd0, 2'd0, 2'd0, 8'd50,  2'd0, 32'h00050005, 4'b1010);
      run_op(OP_VSUB,   2'd0, 2'd0, 2'd1, 8'd0,   2'd0, SUB_RES,      4'b1010);
      run_op(OP_VADD,   2'd2, 2'd1, 2'd1, 8'd0,   2'd2, 32'h02020202, 4'b0000);
      run_op(OP_VSTORE, 2'd0, 2'd0, 2'd0, 8'h80,  2'd0, SUB_RES,      4'b0000);

      // Reset in cycle 3 of a VLOAD: only the first three reads may appear.
      @(negedge clock);
      t0 = cyc;
      for (int k = 1; k <= 3; k++) push(K_RD, t0 + k, 8'd10 + 8'(k - 1), 32'd0, 4'd0);
      op = OP_VLOAD; vd = 2'd3; base_addr = 8'd10; dbg_sel = 2'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_strobes", {30'b0, mem_rden, mem_wren}, 32'd0);
      chk("abort_carry", {28'b0, carry}, 32'd0);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1 chk("abort_vreg", dbg_vreg, 32'd0);
      end
      reset = 1'b0;

      // Start held high: back-to-back VLOADs accepted only in IDLE, one per 7 cycles.
      @(negedge clock);
      t0 = cyc;
      for (int j = 0; j < 2; j++) begin
         for (int k = 1; k <= 4; k++)
            push(K_RD, t0 + 7*j + k, 8'd10 + 8'(k - 1), 32'd0, 4'd0);
         push(K_DONE, t0 + 7*j + 6, 8'd0, 32'h04030201, 4'b0000);
      end
      op = OP_VLOAD; vd = 2'd1; base_addr = 8'd10; dbg_sel = 2'd1; start = 1'b1;
      repeat (13) @(negedge clock);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("held_start_completes", {31'b0, busy}, 32'd0);

      repeat (6) @(negedge clock);
      chk("queue_empty", expq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
